// File: rtl/sm3_pkg.sv
// SM3 message-expansion constants, state type and XOR/rotate helpers.
package sm3_pkg;

  localparam logic [31:0] SM3_T0 = 32'h79CC4519;
  localparam logic [31:0] SM3_T1 = 32'h7A879D8A;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] xx;
    xx = {x, x} << n;
    return xx[63:32];
  endfunction

  function automatic logic [31:0] sm3_p1(input logic [31:0] x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

endpackage

// File: rtl/sm3_expnd_word_comb.sv
// Computes the next expanded word W_(j+16) from the current window taps.
// Purely combinational, zero latency; no flow control.
module sm3_expnd_word_comb
  import sm3_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w3_i,
  input  logic [31:0] w7_i,
  input  logic [31:0] w10_i,
  input  logic [31:0] w13_i,
  output logic [31:0] w16_o
);

  assign w16_o = sm3_p1(w0_i ^ w7_i ^ rotl32(w13_i, 5'd15)) ^ rotl32(w3_i, 5'd7) ^ w10_i;

endmodule

// File: rtl/sm3_msg_expnd_stream.sv
// Streams 64 SM3 round tuples per loaded block; first tuple one cycle after accept.
// Stalls with all outputs held while rnd_rdy_i=0; no new block until the stream ends.
module sm3_msg_expnd_stream
  import sm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_vld_i,
  output logic         blk_rdy_o,
  input  logic [511:0] blk_data_i,
  output logic         rnd_vld_o,
  input  logic         rnd_rdy_i,
  output logic [31:0]  wj_o,
  output logic [31:0]  wjj_o,
  output logic [31:0]  tj_o,
  output logic         round_sm_16_o,
  output logic [5:0]   round_idx_o,
  output logic         last_o
);

  state_e      state_q, state_d;
  logic [5:0]  j_q, j_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] w_new;

  sm3_expnd_word_comb u_word (
    .w0_i  (win_q[0]),
    .w3_i  (win_q[3]),
    .w7_i  (win_q[7]),
    .w10_i (win_q[10]),
    .w13_i (win_q[13]),
    .w16_o (w_new)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    case (state_q)
      IDLE: begin
        if (blk_vld_i) begin
          for (int i = 0; i < 16; i++) win_d[i] = blk_data_i[511-32*i -: 32];
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rnd_rdy_i) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_new;
          // Final handshake returns to IDLE, leaving one bubble before the next accept.
          if (j_q == 6'd63) begin
            state_d = IDLE;
            j_d     = '0;
          end else begin
            j_d = j_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  assign blk_rdy_o     = (state_q == IDLE);
  assign rnd_vld_o     = (state_q == RUN);
  assign wj_o          = win_q[0];
  assign wjj_o         = win_q[0] ^ win_q[4];
  assign round_sm_16_o = ~|j_q[5:4];
  assign tj_o          = rotl32(round_sm_16_o ? SM3_T0 : SM3_T1, j_q[4:0]);
  assign round_idx_o   = j_q;
  assign last_o        = (j_q == 6'd63);

endmodule

// File: tb/tb_sm3_msg_expnd_stream.sv
// Bench for sm3_msg_expnd_stream: known-answer table, digest, random blocks with stalls.
module tb_sm3_msg_expnd_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_vld_i;
  logic         blk_rdy_o;
  logic [511:0] blk_data_i;
  logic         rnd_vld_o;
  logic         rnd_rdy_i;
  logic [31:0]  wj_o, wjj_o, tj_o;
  logic         round_sm_16_o;
  logic [5:0]   round_idx_o;
  logic         last_o;

  sm3_msg_expnd_stream dut (
    .clk           (clk),
    .rst           (rst),
    .blk_vld_i     (blk_vld_i),
    .blk_rdy_o     (blk_rdy_o),
    .blk_data_i    (blk_data_i),
    .rnd_vld_o     (rnd_vld_o),
    .rnd_rdy_i     (rnd_rdy_i),
    .wj_o          (wj_o),
    .wjj_o         (wjj_o),
    .tj_o          (tj_o),
    .round_sm_16_o (round_sm_16_o),
    .round_idx_o   (round_idx_o),
    .last_o        (last_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] T0 = 32'h79CC4519;
  localparam logic [31:0] T1 = 32'h7A879D8A;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mw    [0:67];
  logic [31:0] g_wj  [64];
  logic [31:0] g_wjj [64];
  logic [31:0] g_tj  [64];
  logic        g_sm  [64];

  typedef struct {
    int          j;
    int          kind;   // 0 wj, 1 wjj, 2 tj, 3 round_sm_16
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] brotl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] bp1(input logic [31:0] x);
    return x ^ brotl(x, 15) ^ brotl(x, 23);
  endfunction

  function automatic logic [31:0] exp_tj(input int j);
    return brotl((j < 16) ? T0 : T1, j);
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Whole W0..W67 schedule straight from the recurrence.
  task automatic build_model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) mw[i] = b[511-32*i -: 32];
    for (int j = 16; j < 68; j++)
      mw[j] = bp1(mw[j-16] ^ mw[j-9] ^ brotl(mw[j-3], 15)) ^ brotl(mw[j-13], 7) ^ mw[j-6];
  endtask

  function automatic logic [255:0] sm3_digest();
    logic [31:0] iv [8];
    logic [31:0] a, b, c, d, e, f, g, h, ss1, ss2, ff, gg, tt1, tt2;
    iv[0] = 32'h7380166F; iv[1] = 32'h4914B2B9; iv[2] = 32'h172442D7; iv[3] = 32'hDA8A0600;
    iv[4] = 32'hA96F30BC; iv[5] = 32'h163138AA; iv[6] = 32'hE38DEE4D; iv[7] = 32'hB0FB0E4E;
    a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3]; e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int j = 0; j < 64; j++) begin
      ss1 = brotl(brotl(a, 12) + e + g_tj[j], 7);
      ss2 = ss1 ^ brotl(a, 12);
      ff  = (j < 16) ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + g_wjj[j];
      tt2 = gg + h + ss1 + g_wj[j];
      d = c; c = brotl(b, 9); b = a; a = tt1;
      h = g; g = brotl(f, 19); f = e; e = tt2 ^ brotl(tt2, 9) ^ brotl(tt2, 17);
    end
    return {a ^ iv[0], b ^ iv[1], c ^ iv[2], d ^ iv[3], e ^ iv[4], f ^ iv[5], g ^ iv[6], h ^ iv[7]};
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with the model built.
  task automatic offer_block(input logic [511:0] b, input string tag);
    int n = 0;
    while (!blk_rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept ready"}, blk_rdy_o, 1'b1);
    blk_data_i = b;
    blk_vld_i  = 1'b1;
    @(negedge clk);
    blk_vld_i  = 1'b0;
    check({tag, " first valid"}, {rnd_vld_o, blk_rdy_o}, 2'b10);
    build_model(b);
  endtask

  // Called at a negedge where the first tuple is visible; returns just before the last handshake edge.
  task automatic stream_block(input int duty, input bit junk, input string tag);
    logic [104:0] cur, prev, exp;
    bit prev_stall = 1'b0;
    int k = 0;
    int cyc = 0;
    prev = '0;
    forever begin
      cur = {rnd_vld_o, wj_o, wjj_o, tj_o, round_sm_16_o, round_idx_o, last_o};
      if (prev_stall) check($sformatf("%s hold j=%0d", tag, k), cur, prev);
      if (!rnd_vld_o) begin
        check($sformatf("%s valid j=%0d", tag, k), rnd_vld_o, 1'b1);
        break;
      end
      rnd_rdy_i = ($urandom_range(0, 99) < duty);
      if (junk) begin
        blk_vld_i  = 1'($urandom_range(0, 1));
        blk_data_i = rand_blk();
      end
      if (rnd_rdy_i) begin
        exp = {1'b1, mw[k], mw[k] ^ mw[k+4], exp_tj(k), (k < 16), 6'(k), (k == 63)};
        check($sformatf("%s tuple j=%0d", tag, k), cur, exp);
        g_wj[k] = wj_o; g_wjj[k] = wjj_o; g_tj[k] = tj_o; g_sm[k] = round_sm_16_o;
        k++;
      end
      prev_stall = !rnd_rdy_i;
      prev = cur;
      if (k == 64) break;
      cyc++;
      if (cyc > 4000) begin
        check({tag, " stream timeout"}, 32'(k), 32'd64);
        break;
      end
      @(negedge clk);
    end
    blk_vld_i = 1'b0;
  endtask

  logic [511:0] abc, blk_a, blk_b;
  logic [31:0]  got;
  int           n;

  initial begin
    tbl[0] = '{0, 0, 32'h61626380};
    tbl[1] = '{0, 1, 32'h61626380};
    tbl[2] = '{0, 2, 32'h79CC4519};
    tbl[3] = '{0, 3, 32'h1};
    tbl[4] = '{12, 1, 32'h9092E200};
    tbl[5] = '{16, 0, 32'h9092E200};
    tbl[6] = '{16, 2, 32'h9D8A7A87};
    tbl[7] = '{16, 3, 32'h0};
    tbl[8] = '{33, 2, 32'hF50F3B14};
    abc = {32'h61626380, 448'h0, 32'h00000018};

    rst = 1'b1; blk_vld_i = 1'b0; blk_data_i = '0; rnd_rdy_i = 1'b0;
    #12;
    check("reset outputs",
          {blk_rdy_o, rnd_vld_o, wj_o, wjj_o, tj_o, round_sm_16_o, round_idx_o, last_o},
          {1'b1, 1'b0, 32'h0, 32'h0, T0, 1'b1, 6'd0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", {blk_rdy_o, rnd_vld_o, round_idx_o}, {1'b1, 1'b0, 6'd0});

    // Known answer, no stalls
    offer_block(abc, "abc");
    stream_block(100, 1'b0, "abc");
    for (int i = 0; i < 9; i++) begin
      case (tbl[i].kind)
        0:       got = g_wj[tbl[i].j];
        1:       got = g_wjj[tbl[i].j];
        2:       got = g_tj[tbl[i].j];
        default: got = {31'b0, g_sm[tbl[i].j]};
      endcase
      check($sformatf("abc table j=%0d kind=%0d", tbl[i].j, tbl[i].kind), got, tbl[i].exp);
    end
    check("abc digest", sm3_digest(),
          256'h66C7F0F462EEEDD9D1F2D46BDC10E4E24167C4875CF2F7A2297DA02B8F4BA8E0);

    // Same block under heavy backpressure with blk_vld_i noise
    @(negedge clk);
    offer_block(abc, "abc_bp");
    stream_block(30, 1'b1, "abc_bp");
    check("abc_bp digest", sm3_digest(),
          256'h66C7F0F462EEEDD9D1F2D46BDC10E4E24167C4875CF2F7A2297DA02B8F4BA8E0);

    // Random blocks
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      offer_block(rand_blk(), $sformatf("rnd%0d", r));
      stream_block(int'($urandom_range(30, 100)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    // Framing: next block offered during the final handshake
    blk_a = rand_blk();
    blk_b = rand_blk();
    @(negedge clk);
    offer_block(blk_a, "frmA");
    stream_block(70, 1'b1, "frmA");
    blk_data_i = blk_b;
    blk_vld_i  = 1'b1;
    @(negedge clk);
    check("frame bubble", {rnd_vld_o, blk_rdy_o, round_idx_o, last_o}, {1'b0, 1'b1, 6'd0, 1'b0});
    @(negedge clk);
    blk_vld_i = 1'b0;
    check("frame B start", {rnd_vld_o, blk_rdy_o, round_idx_o, wj_o}, {1'b1, 1'b0, 6'd0, blk_b[511:480]});
    build_model(blk_b);
    stream_block(100, 1'b0, "frmB");

    // Reset at j=20
    @(negedge clk);
    offer_block(rand_blk(), "pre_rst");
    rnd_rdy_i = 1'b1;
    n = 0;
    while (round_idx_o != 6'd20 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach j=20", round_idx_o, 6'd20);
    rst = 1'b1;
    #1;
    check("mid-run reset", {rnd_vld_o, blk_rdy_o, round_idx_o, tj_o, round_sm_16_o},
          {1'b0, 1'b1, 6'd0, T0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    rnd_rdy_i = 1'b0;
    @(negedge clk);
    offer_block(rand_blk(), "post_rst");
    stream_block(50, 1'b0, "post_rst");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
